// File: rtl/pin_cond_pkg.sv
// rtl/pin_cond_pkg.sv - shared defaults and counter sizing for the pin conditioner
package pin_cond_pkg;

    localparam int NUM_CH_DEF          = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

    // Wide enough to hold 0..cycles, so DEBOUNCE_CYCLES=1 still gets one bit
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/pin_cond_channel.sv
// rtl/pin_cond_channel.sv - one pin: 2-flop synchroniser, debounce filter, strobes, optional toggle
// Toggle flop is only built when PIN_COND_TOGGLE_EN is defined.
module pin_cond_channel
    import pin_cond_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic RESET_LEVEL     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall,
    output logic toggle
);

    localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          accept;

    assign accept = (sync2 != level) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= RESET_LEVEL;
            sync2 <= RESET_LEVEL;
            level <= RESET_LEVEL;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sync2;
                cnt   <= '0;
                rise  <= sync2;
                fall  <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef PIN_COND_TOGGLE_EN
    // Flips on the same edge that raises rise, so toggle changes with the strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            toggle <= 1'b0;
        end else if (accept && sync2) begin
            toggle <= ~toggle;
        end
    end
`else
    assign toggle = 1'b0;
`endif

endmodule

// File: rtl/pin_conditioner.sv
// rtl/pin_conditioner.sv - top: NUM_CH independent conditioned pad inputs
// Optional push-on/push-off toggle outputs enabled by PIN_COND_TOGGLE_EN.
module pin_conditioner
    import pin_cond_pkg::*;
#(
    parameter int                NUM_CH          = NUM_CH_DEF,
    parameter int                DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic [NUM_CH-1:0] RESET_LEVEL     = {NUM_CH{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] pin_i,
    output logic [NUM_CH-1:0] level_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic [NUM_CH-1:0] toggle_o
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pin_cond_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL[g])
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .pin    (pin_i[g]),
            .level  (level_o[g]),
            .rise   (rise_o[g]),
            .fall   (fall_o[g]),
            .toggle (toggle_o[g])
        );
    end

endmodule
